wash_seq: RTL and testbench
===========================

Name: wash_seq

Overview:
- Wash-cycle controller downstream of the pre-stage (balance entry / mode select / parameter entry).
- On a start request it checks and deducts the mode cost from the BCD balance, then sequences FILL -> WASH -> RINSE -> SPIN with per-mode 1-second countdowns. It supports pause/resume and raises a timed completion alarm.
- Drives the phase lights and the two-digit remaining-time display digits that feed the scan4 display scanner.

Parameters:
- TICK_CYCLES, 100_000_000, clk cycles per 1 s tick (set to 4 in simulation).
- ALARM_CYCLES, 250_000_000, clk cycles the done alarm stays high (2.5 s; set to 10 in simulation).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle pulse: request cycle start (pre-stage isOn qualified by confirm button)
- pause  in  1  single-cycle pulse: toggle pause/resume
- mode  in  2  wash mode, sampled on accepted start: 0 quick, 1 standard, 2 heavy, 3 spin-only
- bal_in  in  12  BCD balance {hundreds, tens, ones}, sampled on start
- bal_out  out  12  BCD balance after deduction
- bal_wr  out  1  one-cycle pulse when bal_out is valid (accepted start)
- reject  out  1  one-cycle pulse: start refused (insufficient balance)
- busy  out  1  high in any state except IDLE and DONE
- phase_light  out  4  one-hot {SPIN, RINSE, WASH, FILL}; 0 when not running
- paused  out  1  high in PAUSE
- rem_tens  out  4  BCD tens of seconds remaining in the current phase
- rem_ones  out  4  BCD ones of seconds remaining in the current phase
- alarm  out  1  high for ALARM_CYCLES after completion

Behaviour:
- Reset (rst=1 at posedge clk): state IDLE; all outputs 0; tick and alarm counters 0; bal_out=0. A reset mid-run aborts the cycle with no refund.
- States: IDLE, FILL, WASH, RINSE, SPIN, PAUSE, DONE.
- Mode table, durations in s for fill/wash/rinse/spin, plus cost:
  - quick: 5/10/5/5, cost 3
  - standard: 10/30/15/10, cost 5
  - heavy: 15/60/30/20, cost 8
  - spin-only: 0/0/0/15, cost 2
- IDLE + start:
  - If bal_in >= cost: bal_out = bal_in - cost in BCD, with borrow propagated ones->tens->hundreds. Pulse bal_wr.
  - Then enter the first phase with non-zero duration, load rem with that duration, and clear the tick counter. All of this happens in the cycle after start.
  - Otherwise pulse reject and stay in IDLE.
  - pause is ignored in IDLE and DONE.
- Running phase, countdown:
  - The tick counter counts 0..TICK_CYCLES-1; a tick fires at terminal count.
  - On a tick: rem -= 1 as a 2-digit BCD decrement (x0 -> (x-1)9).
  - A tick with rem == 01 moves to the next non-zero-duration phase in the same cycle and loads its duration.
  - After SPIN, the next state is DONE.
  - Zero-duration phases are never entered.
- Pause:
  - pause in FILL/WASH/RINSE/SPIN -> PAUSE; the return phase, rem and the tick counter are frozen.
  - pause in PAUSE -> resume the saved phase with counters unchanged.
  - If pause and the tick fire in the same cycle, pause wins and the tick is discarded (the counter holds at terminal count and fires on the first cycle after resume).
  - start in any non-IDLE state is ignored.
- DONE:
  - alarm=1, rem=00, phase_light=0.
  - Alarm counter runs ALARM_CYCLES, then alarm=0 and state -> IDLE.
  - start during DONE is ignored.
- Outputs are registered (Moore). phase_light is one-hot of the current phase, or of the saved phase while in PAUSE, with paused=1.
- bal_out holds its value until the next accepted start or reset.

Decomposition:
- Shared package wash_pkg holds:
  - the state enum;
  - mode encodings;
  - per-mode duration table (BCD pairs) and cost table;
  - a function next_phase(mode, current), which skips zero durations.
- One sub-module, bcd_dec2: 2-digit BCD down-counter with load, enable and zero/one flags, used for rem.
- The BCD balance subtract stays inline.

Test Plan (TICK_CYCLES=4, ALARM_CYCLES=10):
- bal_in=0x012, mode=0, start -> bal_wr with bal_out=0x009; FILL with rem=05; after 5 ticks (20 cycles) WASH with rem=10; full run ends in DONE; alarm high 10 cycles; then IDLE.
- bal_in=0x002, mode=2, start -> reject pulse; state stays IDLE; bal_wr=0; busy=0.
- bal_in=0x100, mode=3, start -> bal_out=0x098; first phase SPIN with rem=15; phase_light=1000; FILL/WASH/RINSE never asserted.
- mode=1, pause at WASH rem=27 -> paused=1 and rem holds 27 for 50 cycles; pause again -> resumes WASH; rem reaches 26 within 4 cycles.
- pause pulse on the same cycle as a tick with rem=01 -> PAUSE with rem=01 still shown; after resume, the transition to the next phase happens on the first cycle.
- rst asserted mid-RINSE -> next cycle IDLE; all outputs 0; bal_out=0x000.

Source files
------------

// File: rtl/wash_pkg.sv
// Shared types and per-mode tables for the wash-cycle controller.
// Durations are BCD seconds so they can be loaded straight into the display counter.
package wash_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WASH  = 3'd2,
        RINSE = 3'd3,
        SPIN  = 3'd4,
        PAUSE = 3'd5,
        DONE  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        MODE_QUICK    = 2'd0,
        MODE_STANDARD = 2'd1,
        MODE_HEAVY    = 2'd2,
        MODE_SPIN     = 2'd3
    } mode_t;

    function automatic logic [7:0] phase_dur(input mode_t m, input state_t p);
        logic [31:0] row;
        logic [7:0]  res;
        case (m)
            MODE_QUICK:    row = 32'h05_10_05_05;
            MODE_STANDARD: row = 32'h10_30_15_10;
            MODE_HEAVY:    row = 32'h15_60_30_20;
            MODE_SPIN:     row = 32'h00_00_00_15;
            default:       row = 32'h00_00_00_00;
        endcase
        case (p)
            FILL:    res = row[31:24];
            WASH:    res = row[23:16];
            RINSE:   res = row[15:8];
            SPIN:    res = row[7:0];
            default: res = 8'h00;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] mode_cost(input mode_t m);
        logic [3:0] res;
        case (m)
            MODE_QUICK:    res = 4'd3;
            MODE_STANDARD: res = 4'd5;
            MODE_HEAVY:    res = 4'd8;
            MODE_SPIN:     res = 4'd2;
            default:       res = 4'd9;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] light_of(input state_t p);
        logic [3:0] res;
        case (p)
            FILL:    res = 4'b0001;
            WASH:    res = 4'b0010;
            RINSE:   res = 4'b0100;
            SPIN:    res = 4'b1000;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    // Every mode has a non-zero spin, so skipping stops at SPIN at the latest.
    function automatic state_t next_phase(input mode_t m, input state_t cur);
        state_t n;
        case (cur)
            IDLE:    n = FILL;
            FILL:    n = WASH;
            WASH:    n = RINSE;
            RINSE:   n = SPIN;
            default: n = DONE;
        endcase
        for (int i = 0; i < 3; i++) begin
            if (n != DONE && n != SPIN && phase_dur(m, n) == 8'h00) begin
                n = state_t'(3'(n) + 3'd1);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/wash_seq_if.sv
// Control/status bundle between the pre-stage and the wash sequencer.
interface wash_seq_if;
    logic        start;
    logic        pause;
    logic [1:0]  mode;
    logic [11:0] bal_in;
    logic [11:0] bal_out;
    logic        bal_wr;
    logic        reject;
    logic        busy;
    logic [3:0]  phase_light;
    logic        paused;
    logic [3:0]  rem_tens;
    logic [3:0]  rem_ones;
    logic        alarm;

    modport master (
        output start, pause, mode, bal_in,
        input  bal_out, bal_wr, reject, busy, phase_light, paused, rem_tens, rem_ones, alarm
    );

    modport slave (
        input  start, pause, mode, bal_in,
        output bal_out, bal_wr, reject, busy, phase_light, paused, rem_tens, rem_ones, alarm
    );
endinterface

// File: rtl/wash_seq_bcd_dec2.sv
// Two-digit BCD down-counter with load; holds the seconds remaining in a phase.
module bcd_dec2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       en,
    output logic [7:0] value,
    output logic       is_zero,
    output logic       is_one
);
    logic [7:0] cnt_r;

    // Load has priority over decrement; x0 borrows into the tens digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 8'h00;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en) begin
            if (cnt_r[3:0] == 4'd0) begin
                cnt_r[3:0] <= 4'd9;
                cnt_r[7:4] <= (cnt_r[7:4] == 4'd0) ? 4'd9 : cnt_r[7:4] - 4'd1;
            end else begin
                cnt_r[3:0] <= cnt_r[3:0] - 4'd1;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign value   = cnt_r;
    assign is_zero = (cnt_r == 8'h00);
    assign is_one  = (cnt_r == 8'h01);
endmodule

// File: rtl/wash_seq.sv
// Wash-cycle sequencer: charges the BCD balance, then runs FILL/WASH/RINSE/SPIN
// on 1 s ticks with pause/resume and a timed completion alarm.
module wash_seq
    import wash_pkg::*;
#(
    parameter int TICK_CYCLES  = 100_000_000,
    parameter int ALARM_CYCLES = 250_000_000
) (
    input  logic       clk,
    input  logic       rst,
    wash_seq_if.slave  bus
);
    localparam int TW = $clog2(TICK_CYCLES + 1);
    localparam int AW = $clog2(ALARM_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CYCLES - 1);

    state_t        state_r, saved_r;
    mode_t         mode_r;
    logic [TW-1:0] tick_cnt_r;
    logic [AW-1:0] alarm_cnt_r;
    logic [11:0]   bal_out_r;
    logic          bal_wr_r, reject_r, busy_r, paused_r, alarm_r;
    logic [3:0]    phase_light_r;

    logic [3:0]    cost_s, ones_s, tens_s, hund_s;
    logic          bal_ok_s, borrow_o_s, borrow_t_s;
    logic          running_s, tick_due_s, phase_end_s;
    state_t        first_s, nxt_s;
    logic          dec_load_s, dec_en_s;
    logic [7:0]    dec_val_s, rem_s;
    logic          rem_zero_s, rem_one_s;

    // BCD balance check and subtract of the single-digit cost, borrowing upward.
    always_comb begin
        cost_s     = mode_cost(mode_t'(bus.mode));
        bal_ok_s   = (bus.bal_in[11:4] != 8'h00) || (bus.bal_in[3:0] >= cost_s);
        borrow_o_s = (bus.bal_in[3:0] < cost_s);
        borrow_t_s = borrow_o_s && (bus.bal_in[7:4] == 4'd0);
        if (borrow_o_s) begin
            ones_s = bus.bal_in[3:0] + 4'd10 - cost_s;
            tens_s = (bus.bal_in[7:4] == 4'd0) ? 4'd9 : bus.bal_in[7:4] - 4'd1;
        end else begin
            ones_s = bus.bal_in[3:0] - cost_s;
            tens_s = bus.bal_in[7:4];
        end
        if (borrow_t_s) begin
            hund_s = bus.bal_in[11:8] - 4'd1;
        end else begin
            hund_s = bus.bal_in[11:8];
        end
    end

    assign running_s   = (state_r == FILL) || (state_r == WASH) || (state_r == RINSE) || (state_r == SPIN);
    assign tick_due_s  = (tick_cnt_r == TICK_LAST);
    assign phase_end_s = rem_one_s || rem_zero_s;
    assign first_s     = next_phase(mode_t'(bus.mode), IDLE);
    assign nxt_s       = next_phase(mode_r, state_r);

    // Remaining-time counter control; a pause in the tick cycle discards the tick.
    always_comb begin
        dec_load_s = 1'b0;
        dec_en_s   = 1'b0;
        dec_val_s  = 8'h00;
        if (state_r == IDLE && bus.start && bal_ok_s) begin
            dec_load_s = 1'b1;
            dec_val_s  = phase_dur(mode_t'(bus.mode), first_s);
        end else if (running_s && !bus.pause && tick_due_s) begin
            if (phase_end_s) begin
                dec_load_s = 1'b1;
                dec_val_s  = phase_dur(mode_r, nxt_s);
            end else begin
                dec_en_s = 1'b1;
            end
        end else begin
            dec_load_s = 1'b0;
        end
    end

    bcd_dec2 u_rem (
        .clk      (clk),
        .rst      (rst),
        .load     (dec_load_s),
        .load_val (dec_val_s),
        .en       (dec_en_s),
        .value    (rem_s),
        .is_zero  (rem_zero_s),
        .is_one   (rem_one_s)
    );

    // Main sequencer with registered Moore outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            saved_r       <= IDLE;
            mode_r        <= MODE_QUICK;
            tick_cnt_r    <= {TW{1'b0}};
            alarm_cnt_r   <= {AW{1'b0}};
            bal_out_r     <= 12'h000;
            bal_wr_r      <= 1'b0;
            reject_r      <= 1'b0;
            busy_r        <= 1'b0;
            paused_r      <= 1'b0;
            alarm_r       <= 1'b0;
            phase_light_r <= 4'b0000;
        end else begin
            bal_wr_r <= 1'b0;
            reject_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start && bal_ok_s) begin
                        bal_out_r     <= {hund_s, tens_s, ones_s};
                        bal_wr_r      <= 1'b1;
                        mode_r        <= mode_t'(bus.mode);
                        state_r       <= first_s;
                        tick_cnt_r    <= {TW{1'b0}};
                        busy_r        <= 1'b1;
                        phase_light_r <= light_of(first_s);
                    end else if (bus.start) begin
                        reject_r <= 1'b1;
                    end
                end
                FILL, WASH, RINSE, SPIN: begin
                    if (bus.pause) begin
                        saved_r  <= state_r;
                        state_r  <= PAUSE;
                        paused_r <= 1'b1;
                    end else if (tick_due_s) begin
                        tick_cnt_r <= {TW{1'b0}};
                        if (phase_end_s) begin
                            state_r       <= nxt_s;
                            phase_light_r <= light_of(nxt_s);
                            busy_r        <= (nxt_s != DONE);
                            alarm_r       <= (nxt_s == DONE);
                            alarm_cnt_r   <= {AW{1'b0}};
                        end
                    end else begin
                        tick_cnt_r <= tick_cnt_r + TW'(1);
                    end
                end
                PAUSE: begin
                    if (bus.pause) begin
                        state_r  <= saved_r;
                        paused_r <= 1'b0;
                    end
                end
                DONE: begin
                    if (alarm_cnt_r == ALARM_LAST) begin
                        state_r     <= IDLE;
                        alarm_r     <= 1'b0;
                        alarm_cnt_r <= {AW{1'b0}};
                    end else begin
                        alarm_cnt_r <= alarm_cnt_r + AW'(1);
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    busy_r        <= 1'b0;
                    paused_r      <= 1'b0;
                    alarm_r       <= 1'b0;
                    phase_light_r <= 4'b0000;
                end
            endcase
        end
    end

    assign bus.bal_out     = bal_out_r;
    assign bus.bal_wr      = bal_wr_r;
    assign bus.reject      = reject_r;
    assign bus.busy        = busy_r;
    assign bus.paused      = paused_r;
    assign bus.alarm       = alarm_r;
    assign bus.phase_light = phase_light_r;
    assign bus.rem_tens    = rem_s[7:4];
    assign bus.rem_ones    = rem_s[3:0];
endmodule

// File: tb/tb_wash_seq.sv
// Self-checking bench for wash_seq: expected behaviour comes from a timeline model
// (elapsed seconds against cumulative phase durations) and decimal balance arithmetic.
module tb_wash_seq;
    localparam int TICK  = 4;
    localparam int ALARM = 10;
    localparam int DUR [4][4] = '{'{5, 10, 5, 5}, '{10, 30, 15, 10}, '{15, 60, 30, 20}, '{0, 0, 0, 15}};
    localparam int COST [4]   = '{3, 5, 8, 2};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [11:0] exp_bal = 12'h000;
    logic [14:0] obs;

    wash_seq_if bus ();

    wash_seq #(.TICK_CYCLES(TICK), .ALARM_CYCLES(ALARM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {busy, paused, alarm, phase_light, rem_tens, rem_ones}
    assign obs = {bus.busy, bus.paused, bus.alarm, bus.phase_light, bus.rem_tens, bus.rem_ones};

    function automatic int bcd_to_int(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [11:0] int_to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [14:0] pack(input logic b, input logic p, input logic a,
                                         input logic [3:0] l, input int rem);
        return {b, p, a, l, 4'(rem / 10), 4'(rem % 10)};
    endfunction

    function automatic int total_of(input int m);
        return DUR[m][0] + DUR[m][1] + DUR[m][2] + DUR[m][3];
    endfunction

    // Expected status k cycles after the accepted start.
    function automatic logic [14:0] timeline(input int m, input int k);
        int s, cum, total;
        logic [14:0] r;
        total = total_of(m);
        s     = k / TICK;
        cum   = 0;
        r     = pack(1'b0, 1'b0, 1'b0, 4'd0, 0);
        if (s < total) begin
            for (int p = 0; p < 4; p++) begin
                if (s >= cum && s < cum + DUR[m][p])
                    r = pack(1'b1, 1'b0, 1'b0, 4'(1 << p), cum + DUR[m][p] - s);
                cum += DUR[m][p];
            end
        end else if (k < total * TICK + ALARM) begin
            r = pack(1'b0, 1'b0, 1'b1, 4'd0, 0);
        end
        return r;
    endfunction

    // Called at a negedge; pulses start and checks the response one cycle later.
    task automatic do_start(input logic [11:0] bal, input int m);
        logic ok;
        int   nb;
        ok = bcd_to_int(bal) >= COST[m];
        nb = ok ? bcd_to_int(bal) - COST[m] : bcd_to_int(exp_bal);
        bus.bal_in = bal;
        bus.mode   = 2'(m);
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.bal_in = 12'($urandom);
        n_checks++;
        if ({bus.bal_wr, bus.reject, bus.bal_out} !== {ok, ~ok, int_to_bcd(nb)}) begin
            n_fail++;
            $display("FAIL start_resp bal_in=%h mode=%0d: got wr=%b rej=%b bal_out=%h, want wr=%b rej=%b bal_out=%h",
                     bal, m, bus.bal_wr, bus.reject, bus.bal_out, ok, ~ok, int_to_bcd(nb));
        end
        exp_bal = int_to_bcd(nb);
    endtask

    task automatic test_run(input logic [11:0] bal, input int m, input bit noise);
        logic        ok;
        int          total, last;
        logic [14:0] want;
        ok    = bcd_to_int(bal) >= COST[m];
        total = total_of(m);
        last  = ok ? total * TICK + ALARM : 1;
        do_start(bal, m);
        for (int k = 0; k <= last; k++) begin
            want = ok ? timeline(m, k) : pack(1'b0, 1'b0, 1'b0, 4'd0, 0);
            n_checks++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL run_status mode=%0d k=%0d: got %b, want %b", m, k, obs, want);
            end
            if (k >= 1) begin
                n_checks++;
                if ({bus.bal_wr, bus.reject, bus.bal_out} !== {2'b00, exp_bal}) begin
                    n_fail++;
                    $display("FAIL bal_hold k=%0d: got wr=%b rej=%b bal_out=%h, want 0 0 %h",
                             k, bus.bal_wr, bus.reject, bus.bal_out, exp_bal);
                end
            end
            bus.start = 1'b0;
            bus.pause = 1'b0;
            if (noise && k < last) begin
                bus.mode = 2'($urandom_range(0, 3));
                if (ok) bus.start = 1'($urandom_range(0, 1));
                if (!ok || k >= total * TICK) bus.pause = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.start  = 1'b0;
        bus.pause  = 1'b0;
        bus.mode   = 2'd0;
        bus.bal_in = 12'h000;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({obs, bus.bal_wr, bus.reject, bus.bal_out} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_state: got status=%b wr=%b rej=%b bal_out=%h, want all zero",
                     obs, bus.bal_wr, bus.reject, bus.bal_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_boundaries();
        test_run(12'h012, 0, 1'b0);   // quick, ones borrow
        test_run(12'h002, 2, 1'b1);   // reject
        test_run(12'h100, 3, 1'b0);   // spin-only, double borrow
        test_run(12'h003, 0, 1'b1);   // balance exactly equals cost
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 8; r++)
            test_run({4'($urandom_range(0, 1)), 4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))},
                     int'($urandom_range(0, 3)), 1'b1);
    endtask

    task automatic wait_rem(input logic [3:0] light, input logic [7:0] rem, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus.phase_light == light && {bus.rem_tens, bus.rem_ones} == rem) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s: timed out, got light=%b rem=%h, want light=%b rem=%h",
                     tag, bus.phase_light, {bus.rem_tens, bus.rem_ones}, light, rem);
        end
    endtask

    task automatic pulse_pause();
        bus.pause = 1'b1;
        @(negedge clk);
        bus.pause = 1'b0;
    endtask

    task automatic test_pause_resume();
        bit got26 = 1'b0;
        do_start(12'h050, 1);
        wait_rem(4'b0010, 8'h27, "reach_wash_27");
        pulse_pause();
        for (int i = 0; i < 50; i++) begin
            n_checks++;
            if (obs !== pack(1'b1, 1'b1, 1'b0, 4'b0010, 27)) begin
                n_fail++;
                $display("FAIL pause_hold i=%0d: got %b, want %b", i, obs, pack(1'b1, 1'b1, 1'b0, 4'b0010, 27));
            end
            @(negedge clk);
        end
        pulse_pause();
        n_checks++;
        if (obs !== pack(1'b1, 1'b0, 1'b0, 4'b0010, 27)) begin
            n_fail++;
            $display("FAIL resume_state: got %b, want %b", obs, pack(1'b1, 1'b0, 1'b0, 4'b0010, 27));
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.phase_light == 4'b0010 && {bus.rem_tens, bus.rem_ones} == 8'h26) got26 = 1'b1;
        end
        n_checks++;
        if (!got26) begin
            n_fail++;
            $display("FAIL resume_tick: got rem=%h, want 26 within 4 cycles", {bus.rem_tens, bus.rem_ones});
        end
    endtask

    task automatic test_pause_on_tick();
        wait_rem(4'b0010, 8'h01, "reach_wash_01");
        repeat (3) @(negedge clk);
        pulse_pause();
        repeat (5) begin
            n_checks++;
            if (obs !== pack(1'b1, 1'b1, 1'b0, 4'b0010, 1)) begin
                n_fail++;
                $display("FAIL pause_on_tick: got %b, want %b", obs, pack(1'b1, 1'b1, 1'b0, 4'b0010, 1));
            end
            @(negedge clk);
        end
        pulse_pause();
        n_checks++;
        if (obs !== pack(1'b1, 1'b0, 1'b0, 4'b0010, 1)) begin
            n_fail++;
            $display("FAIL resume_at_01: got %b, want %b", obs, pack(1'b1, 1'b0, 1'b0, 4'b0010, 1));
        end
        @(negedge clk);
        n_checks++;
        if (obs !== pack(1'b1, 1'b0, 1'b0, 4'b0100, 15)) begin
            n_fail++;
            $display("FAIL first_cycle_advance: got %b, want %b", obs, pack(1'b1, 1'b0, 1'b0, 4'b0100, 15));
        end
    endtask

    task automatic test_reset_mid_run();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_bal = 12'h000;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({obs, bus.bal_wr, bus.reject, bus.bal_out} !== 29'd0) begin
                n_fail++;
                $display("FAIL mid_run_reset i=%0d: got status=%b wr=%b rej=%b bal_out=%h, want all zero",
                         i, obs, bus.bal_wr, bus.reject, bus.bal_out);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_boundaries();
        test_back_to_back();
        test_pause_resume();
        test_pause_on_tick();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
